seq_recur: RTL and testbench
============================

SEQ_RECUR -- requirements
Module: seq_recur

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of seeds and result.
REQ-002 SHALL have parameter NWIDTH, default 16, width of the term index i_n.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port i_stb  input  1  request strobe; sampled only in IDLE.
REQ-006 SHALL have port o_busy  output  1  high while a request is in progress.
REQ-007 SHALL have port i_n  input  NWIDTH  index of requested term.
REQ-008 SHALL have port i_seed0  input  WIDTH  term a(0).
REQ-009 SHALL have port i_seed1  input  WIDTH  term a(1).
REQ-010 SHALL have port i_sat  input  1  overflow mode: 1 saturate, 0 wrap modulo 2^WIDTH.
REQ-011 SHALL have port o_fib  output  WIDTH  result a(n); holds last result until next completion.
REQ-012 SHALL have port o_valid  output  1  one-cycle pulse marking o_fib update.
REQ-013 SHALL have port o_ovf  output  1  true value of returned a(n) exceeded 2^WIDTH-1; valid with o_valid, held with o_fib.

Function
REQ-014 SHALL compute a(n) = a(n-1) + a(n-2), with a(0)=i_seed0 and a(1)=i_seed1, all unsigned.
REQ-015 SHALL implement states IDLE and CALC only; IDLE->CALC on i_stb; CALC->IDLE on completion.
REQ-016 SHALL, on the edge k where i_stb=1 in IDLE, capture i_n, i_seed0, i_seed1 and i_sat, and set o_busy=1.
REQ-017 SHALL ignore later changes on i_n, seeds and i_sat until the next capture.
REQ-018 SHALL perform one recurrence step per cycle on edges k+1..k+n: a<=b, b<=a+b, count<=count-1.
REQ-019 SHALL, on edge k+n+1 (count==0 in CALC), set o_fib=a(n), o_valid=1, o_busy=0 and return to IDLE.
REQ-020 SHALL therefore hold o_busy high exactly n+1 cycles; n=0 returns i_seed0 and n=1 returns i_seed1.
REQ-021 SHALL ignore i_stb while in CALC, including on the completion edge.
REQ-022 SHALL accept i_stb held continuously high on the first edge after o_busy falls, giving back-to-back requests with one idle cycle.
REQ-023 SHALL form each sum at WIDTH+1 bits; on carry, wrap mode keeps the low WIDTH bits and saturate mode substitutes all-ones.
REQ-024 SHALL track overflow per term: b's flag is ORed with each carry, a's flag moves with a<=b, and o_ovf reports a's flag.
REQ-025 SHALL not raise o_ovf for an overflow occurring only in a(n+1), the term computed on the final step.
REQ-026 SHALL keep o_valid low in all cycles other than the completion edge.

Reset
REQ-027 SHALL, when i_reset=1 at a rising edge, force IDLE, o_busy=0, o_valid=0, o_fib=0, o_ovf=0 and clear internal registers.
REQ-028 SHALL abort an in-progress request on reset, with no o_valid pulse, and ignore i_stb in that same cycle.

Verification
REQ-029 SHALL pass: seeds 0/1, wrap, i_stb held high, n=1,2,3,4,5 -> o_fib 1,1,2,3,5, o_ovf=0, o_busy widths 2,3,4,5,6 cycles.
REQ-030 SHALL pass: n=0, seeds 7/9 -> o_fib=7 with o_valid on edge k+1; n=1 -> o_fib=9 on edge k+2.
REQ-031 SHALL pass: seeds 2/1 (Lucas), n=10 -> o_fib=123, o_ovf=0; pulse i_stb and change i_n mid-run -> result unchanged, no extra request.
REQ-032 SHALL pass: WIDTH=8, seeds 0/1, n=13 -> 233, o_ovf=0; n=14 wrap -> 121, o_ovf=1; n=14 saturate -> 255, o_ovf=1.
REQ-033 SHALL pass: n=20 request, i_reset asserted at cycle 5 of busy -> o_busy=0, no o_valid, o_fib=0; a following n=3 request -> 2.

Source files
------------

// File: rtl/seq_recur.sv
// seq_recur: two-seed additive recurrence a(n) = a(n-1) + a(n-2), wrap or saturate on overflow.
// Latency: result appears n+1 cycles after the accepting edge, with a one-cycle o_valid pulse.
// Backpressure: none; i_stb is sampled only while idle (o_busy low) and ignored while busy.
module seq_recur #(
    parameter int WIDTH  = 32,
    parameter int NWIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    output logic              o_busy,
    input  logic [NWIDTH-1:0] i_n,
    input  logic [WIDTH-1:0]  i_seed0,
    input  logic [WIDTH-1:0]  i_seed1,
    input  logic              i_sat,
    output logic [WIDTH-1:0]  o_fib,
    output logic              o_valid,
    output logic              o_ovf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t            state_q, state_d;

    // Sliding window over the sequence: a holds the older term, b the newer one.
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    // Per-term sticky flags: set once the true value of that term no longer fits.
    logic              a_ovf_q, a_ovf_d;
    logic              b_ovf_q, b_ovf_d;
    // Remaining recurrence steps.
    logic [NWIDTH-1:0] cnt_q, cnt_d;
    // Overflow mode latched with the request so mid-run changes have no effect.
    logic              sat_q, sat_d;

    // Result registers, held between completions.
    logic [WIDTH-1:0]  fib_q, fib_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    // Next-term datapath.
    logic [WIDTH:0]    sum;
    logic              carry;
    logic [WIDTH-1:0]  step_val;

    // Form a+b one bit wider so the carry out is visible, then wrap or clamp.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        carry    = sum[WIDTH];
        step_val = sum[WIDTH-1:0];
        if (carry && sat_q) begin
            step_val = '1;
        end
    end

    // Next-state and register-update logic for the IDLE/CALC controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        fib_d   = fib_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_stb) begin
                    state_d = S_CALC;
                    a_d     = i_seed0;
                    b_d     = i_seed1;
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    cnt_d   = i_n;
                    sat_d   = i_sat;
                end
            end

            S_CALC: begin
                if (cnt_q == '0) begin
                    // a now holds a(n); b holds a(n+1), whose overflow is not reported.
                    fib_d   = a_q;
                    ovf_d   = a_ovf_q;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    a_d     = b_q;
                    b_d     = step_val;
                    a_ovf_d = b_ovf_q;
                    b_ovf_d = b_ovf_q | carry;
                    cnt_d   = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any request and clears everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            fib_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            fib_q   <= fib_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        o_busy  = (state_q == S_CALC);
        o_fib   = fib_q;
        o_valid = valid_q;
        o_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_seq_recur.sv
// tb_seq_recur: randomized and directed checks of seq_recur (WIDTH=8) against a true-arithmetic model.
// Latency: expects the result n+1 cycles after the accepting edge.
// Backpressure: i_stb held or pulsed while busy must be ignored.
module tb_seq_recur;

    localparam int W  = 8;
    localparam int NW = 16;

    logic          clk;
    logic          rst;
    logic          stb;
    logic          busy;
    logic [NW-1:0] n_in;
    logic [W-1:0]  s0;
    logic [W-1:0]  s1;
    logic          sat;
    logic [W-1:0]  fib;
    logic          valid;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    seq_recur #(
        .WIDTH (W),
        .NWIDTH(NW)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_stb  (stb),
        .o_busy (busy),
        .i_n    (n_in),
        .i_seed0(s0),
        .i_seed1(s1),
        .i_sat  (sat),
        .o_fib  (fib),
        .o_valid(valid),
        .o_ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // True (unbounded) sequence value; the returned term is wrapped or clamped afterwards.
    function automatic void model(input int n, input int a0, input int a1, input bit m_sat,
                                  output logic [W-1:0] e_fib, output bit e_ovf);
        longint unsigned t[$];
        longint unsigned v;
        t.push_back(longint'(a0));
        t.push_back(longint'(a1));
        for (int i = 2; i <= n; i++) begin
            t.push_back(t[i-1] + t[i-2]);
        end
        v     = t[n];
        e_ovf = (v > 64'd255);
        if (e_ovf && m_sat) e_fib = 8'hFF;
        else                e_fib = v[W-1:0];
    endfunction

    // Called at a negedge. keep: leave i_stb high throughout. disturb: poke inputs mid-run.
    // want_fib/want_ovf >= 0 add a check against a hand-derived expected value.
    task automatic run_req(input int n, input int a0, input int a1, input bit m_sat,
                           input bit keep, input bit disturb,
                           input int want_fib, input int want_ovf);
        logic [W-1:0] ef;
        bit           eo;
        int           bc;
        model(n, a0, a1, m_sat, ef, eo);
        n_in = NW'(n);
        s0   = W'(a0);
        s1   = W'(a1);
        sat  = m_sat;
        stb  = 1'b1;
        @(negedge clk);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("valid_at_start", {31'd0, valid}, 32'd0);
        if (!keep) stb = 1'b0;
        bc = 1;
        while (busy && bc <= 200) begin
            if (disturb && bc == 2) begin
                stb  = 1'b1;
                n_in = NW'($urandom_range(0, 50));
                s0   = W'($urandom);
                s1   = W'($urandom);
                sat  = ~sat;
            end else if (!keep) begin
                stb = 1'b0;
            end
            @(negedge clk);
            if (busy) begin
                bc++;
                chk("valid_while_busy", {31'd0, valid}, 32'd0);
            end
        end
        chk("busy_width", bc, n + 1);
        chk("valid_pulse", {31'd0, valid}, 32'd1);
        chk("fib", {24'd0, fib}, {24'd0, ef});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        if (want_fib >= 0) chk("fib_spec", {24'd0, fib}, want_fib);
        if (want_ovf >= 0) chk("ovf_spec", {31'd0, ovf}, want_ovf);
        if (!keep) begin
            @(negedge clk);
            chk("valid_drop", {31'd0, valid}, 32'd0);
            chk("no_extra_req", {31'd0, busy}, 32'd0);
            chk("fib_hold", {24'd0, fib}, {24'd0, ef});
            chk("ovf_hold", {31'd0, ovf}, {31'd0, eo});
        end
    endtask

    initial begin
        int fib_ref [1:5];
        fib_ref = '{1, 1, 2, 3, 5};
        rst  = 1'b1;
        stb  = 1'b0;
        n_in = '0;
        s0   = '0;
        s1   = '0;
        sat  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_fib", {24'd0, fib}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with i_stb held high, seeds 0/1, n = 1..5.
        for (int k = 1; k <= 5; k++) begin
            run_req(k, 0, 1, 1'b0, 1'b1, 1'b0, fib_ref[k], 0);
        end
        stb = 1'b0;
        @(negedge clk);
        chk("held_release_idle", {31'd0, busy}, 32'd0);

        // n=0 and n=1 return the seeds directly.
        run_req(0, 7, 9, 1'b0, 1'b0, 1'b0, 7, 0);
        run_req(1, 7, 9, 1'b0, 1'b0, 1'b0, 9, 0);

        // Lucas numbers with inputs disturbed mid-run.
        run_req(10, 2, 1, 1'b0, 1'b0, 1'b1, 123, 0);

        // 8-bit boundary: overflow only in a(n+1), then in a(n) under both modes.
        run_req(13, 0, 1, 1'b0, 1'b0, 1'b0, 233, 0);
        run_req(14, 0, 1, 1'b0, 1'b0, 1'b0, 121, 1);
        run_req(14, 0, 1, 1'b1, 1'b0, 1'b0, 255, 1);

        // Reset mid-request, with i_stb also high on the reset edge.
        n_in = 16'd20;
        s0   = 8'd0;
        s1   = 8'd1;
        sat  = 1'b0;
        stb  = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        stb = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_fib", {24'd0, fib}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        stb = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, valid, busy}, 32'd0);
        end
        run_req(3, 0, 1, 1'b0, 1'b0, 1'b0, 2, 0);

        // Randomized requests; small seeds half the time so both overflow outcomes appear.
        for (int r = 0; r < 40; r++) begin
            int  rn;
            int  ra;
            int  rb;
            bit  rdis;
            rn = int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0) begin
                ra = int'($urandom_range(0, 3));
                rb = int'($urandom_range(0, 3));
            end else begin
                ra = int'($urandom_range(0, 255));
                rb = int'($urandom_range(0, 255));
            end
            rdis = (rn >= 3) && ($urandom_range(0, 2) == 0);
            run_req(rn, ra, rb, 1'($urandom_range(0, 1)), 1'b0, rdis, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
